spi_byte_ctrl: RTL and testbench



---
 rtl/spi_byte_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_spi_byte_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_ctrl.sv
// Byte-oriented mode-0 SPI master (MSB first) with programmable SCK rate and a slave-select register.
// Optional macro SPI_HOLD_EN adds a one-byte transmit holding register and the HOLD_FULL output.
module spi_byte_ctrl #(
  parameter int unsigned DIVW = 8,
  parameter int unsigned NSS  = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DIV_WE,
  input  logic            SS_WE,
  input  logic            START,
  input  logic [7:0]      WDATA,
  input  logic            MISO,
  output logic            SCK,
  output logic            MOSI,
  output logic [NSS-1:0]  nSS,
  output logic [7:0]      RXD,
  output logic            BUSY,
`ifdef SPI_HOLD_EN
  output logic            HOLD_FULL,
`endif
  output logic            DONE
);

  localparam int unsigned BITW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e          state_q,  state_d;
  logic [DIVW-1:0] div_q,    div_d;
  logic [DIVW-1:0] cnt_q,    cnt_d;
  logic [BITW-1:0] bit_q,    bit_d;
  logic [7:0]      sr_q,     sr_d;
  logic            rx_bit_q, rx_bit_d;
  logic            sck_q,    sck_d;
  logic            mosi_q,   mosi_d;
  logic [NSS-1:0]  nss_q,    nss_d;
  logic [7:0]      rxd_q,    rxd_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
`ifdef SPI_HOLD_EN
  logic [7:0]      hold_q,      hold_d;
  logic            hold_full_q, hold_full_d;
`endif

  logic [DIVW-1:0] div_wr;
  logic [NSS-1:0]  sel_wr;

  assign div_wr = DIVW'(WDATA);
  assign sel_wr = NSS'(WDATA);

  // State and register file; RST aborts any transfer without touching RXD beyond its reset value
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      rx_bit_q    <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b1;
      nss_q       <= '1;
      rxd_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SPI_HOLD_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      rx_bit_q    <= rx_bit_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      nss_q       <= nss_d;
      rxd_q       <= rxd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SPI_HOLD_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    rx_bit_d = rx_bit_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    nss_d    = nss_q;
    rxd_d    = rxd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SPI_HOLD_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (busy_q && START && !hold_full_q) begin
      hold_d      = WDATA;
      hold_full_d = 1'b1;
    end
`endif

    // Configuration is frozen while a byte is on the wire; multi-hot selects deselect everything
    if (!busy_q) begin
      if (DIV_WE) begin
        div_d = div_wr;
      end
      if (SS_WE) begin
        nss_d = $onehot0(sel_wr) ? ~sel_wr : '1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          sr_d    = WDATA;
          mosi_d  = WDATA[7];
          busy_d  = 1'b1;
          bit_d   = '0;
          cnt_d   = DIV_WE ? div_wr : div_q;
          state_d = S_LOW;
        end
      end

      S_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else begin
          sck_d    = 1'b1;
          rx_bit_d = MISO;
          cnt_d    = div_q;
          state_d  = S_HIGH;
        end
      end

      // The MISO bit is merged at the falling edge so bit 0 keeps its transmit value until then
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else if (bit_q == 3'd7) begin
          rxd_d  = {sr_q[6:0], rx_bit_q};
          done_d = 1'b1;
          sck_d  = 1'b0;
          bit_d  = '0;
`ifdef SPI_HOLD_EN
          if (hold_full_q || START) begin
            sr_d        = hold_full_q ? hold_q : WDATA;
            mosi_d      = hold_full_q ? hold_q[7] : WDATA[7];
            hold_full_d = 1'b0;
            cnt_d       = div_q;
            state_d     = S_LOW;
          end else begin
            mosi_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
`else
          mosi_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
`endif
        end else begin
          sck_d   = 1'b0;
          sr_d    = {sr_q[6:0], rx_bit_q};
          mosi_d  = sr_q[6];
          bit_d   = bit_q + 3'd1;
          cnt_d   = div_q;
          state_d = S_LOW;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign SCK  = sck_q;
  assign MOSI = mosi_q;
  assign nSS  = nss_q;
  assign RXD  = rxd_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
`ifdef SPI_HOLD_EN
  assign HOLD_FULL = hold_full_q;
`endif

endmodule

// File: tb/tb_spi_byte_ctrl.sv
// Self-checking bench for spi_byte_ctrl: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized transfers.
module tb_spi_byte_ctrl;

  localparam int unsigned DIVW = 8;
  localparam int unsigned NSS  = 2;

  logic           CLK;
  logic           RST;
  logic           DIV_WE;
  logic           SS_WE;
  logic           START;
  logic [7:0]     WDATA;
  logic           MISO;
  logic           SCK;
  logic           MOSI;
  logic [NSS-1:0] nSS;
  logic [7:0]     RXD;
  logic           BUSY;
  logic           DONE;
  logic           HOLD_FULL;

  spi_byte_ctrl #(.DIVW(DIVW), .NSS(NSS)) dut (
    .CLK(CLK),
    .RST(RST),
    .DIV_WE(DIV_WE),
    .SS_WE(SS_WE),
    .START(START),
    .WDATA(WDATA),
    .MISO(MISO),
    .SCK(SCK),
    .MOSI(MOSI),
    .nSS(nSS),
    .RXD(RXD),
    .BUSY(BUSY),
`ifdef SPI_HOLD_EN
    .HOLD_FULL(HOLD_FULL),
`endif
    .DONE(DONE)
  );

`ifndef SPI_HOLD_EN
  assign HOLD_FULL = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a transfer is "byte m_tx, divider m_d, m_j cycles elapsed since acceptance"
  bit         m_act;
  bit         m_donecyc;
  int         m_j;
  int         m_d;
  logic [7:0] m_tx;
  logic [7:0] m_rx;
  logic [7:0] m_div;
  logic [1:0] m_nss;
  logic [7:0] m_rxd;
  logic [7:0] m_q[$];

  logic       exp_sck, exp_mosi, exp_busy, exp_done, exp_hold;
  logic [1:0] exp_nss;
  logic [7:0] exp_rxd;

  bit         loop_mode;
  bit         rand_miso;
  int         cyc_cnt;
  int         done_seen;
  int         sck_rises;
  logic [7:0] mosi_seq;
  logic       prev_sck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit was_busy;
    bit was_done;
    int p;
    if (RST) begin
      m_act     = 1'b0;
      m_donecyc = 1'b0;
      m_div     = 8'h00;
      m_nss     = 2'b11;
      m_rxd     = 8'h00;
      m_q.delete();
    end else begin
      was_busy  = m_act;
      was_done  = m_donecyc;
      m_donecyc = 1'b0;
      if (!was_busy) begin
        if (DIV_WE) m_div = WDATA;
        if (SS_WE)  m_nss = ($countones(WDATA[1:0]) > 1) ? 2'b11 : ~WDATA[1:0];
      end
      if (m_act) begin
`ifdef SPI_HOLD_EN
        if (START && m_q.size() == 0) m_q.push_back(WDATA);
`endif
        // last cycle of each low phase: MISO is taken at the rising SCK edge that ends it
        if (m_j % (2 * (m_d + 1)) == m_d) m_rx = {m_rx[6:0], MISO};
        m_j++;
        if (m_j == 16 * (m_d + 1)) begin
          m_rxd     = m_rx;
          m_donecyc = 1'b1;
          m_act     = 1'b0;
          if (m_q.size() != 0) begin
            m_tx  = m_q.pop_front();
            m_j   = 0;
            m_rx  = 8'h00;
            m_act = 1'b1;
          end
        end
      end else if (START && !was_done) begin
        m_tx  = WDATA;
        m_d   = int'(m_div);
        m_j   = 0;
        m_rx  = 8'h00;
        m_act = 1'b1;
      end
    end
    exp_busy = m_act;
    exp_done = m_donecyc;
    exp_nss  = m_nss;
    exp_rxd  = m_rxd;
    exp_hold = (m_q.size() != 0);
    if (m_act) begin
      p        = m_j / (m_d + 1);
      exp_sck  = ((p % 2) == 1);
      exp_mosi = m_tx[7 - p / 2];
    end else begin
      exp_sck  = 1'b0;
      exp_mosi = 1'b1;
    end
  endtask

  // One clock: advance the model on the edge, compare every output shortly after it
  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    cyc_cnt++;
    chk("sck",  32'(SCK),  32'(exp_sck));
    chk("mosi", 32'(MOSI), 32'(exp_mosi));
    chk("nss",  32'(nSS),  32'(exp_nss));
    chk("rxd",  32'(RXD),  32'(exp_rxd));
    chk("busy", 32'(BUSY), 32'(exp_busy));
    chk("done", 32'(DONE), 32'(exp_done));
`ifdef SPI_HOLD_EN
    chk("hold_full", 32'(HOLD_FULL), 32'(exp_hold));
`endif
    if (DONE === 1'b1) done_seen++;
    if (SCK === 1'b1 && prev_sck === 1'b0) begin
      sck_rises++;
      mosi_seq = {mosi_seq[6:0], MOSI};
    end
    prev_sck = SCK;
    if (loop_mode)      MISO = MOSI;
    else if (rand_miso) MISO = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (DONE !== 1'b1 && n < 5000);
    if (DONE !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no DONE within %0d cycles", n);
    end
  endtask

  task automatic write_ss(input logic [7:0] v);
    SS_WE = 1'b1; WDATA = v; cyc(); SS_WE = 1'b0;
  endtask

  task automatic write_div(input logic [7:0] v);
    DIV_WE = 1'b1; WDATA = v; cyc(); DIV_WE = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; repeat (2) cyc(); RST = 1'b0;
  endtask

  initial begin
    int t_acc, t1, d0, budget, abort_at;
    bit abort;
    logic [7:0] b;
    RST = 1'b1; DIV_WE = 1'b0; SS_WE = 1'b0; START = 1'b0; WDATA = 8'h00; MISO = 1'b0;
    loop_mode = 1'b0; rand_miso = 1'b0;
    cyc_cnt = 0; done_seen = 0; sck_rises = 0; mosi_seq = 8'h00; prev_sck = 1'b0;
    repeat (3) cyc();
    RST = 1'b0;
    chk("reset_nss",  32'(nSS),  32'h3);
    chk("reset_mosi", 32'(MOSI), 32'h1);
    chk("reset_rxd",  32'(RXD),  32'h0);

    // 1: DIV=0, sel=01, loopback 0xA5
    write_ss(8'h01);
    chk("t1_nss", 32'(nSS), 32'h2);
    write_div(8'h00);
    loop_mode = 1'b1; sck_rises = 0; mosi_seq = 8'h00;
    START = 1'b1; WDATA = 8'hA5; cyc(); START = 1'b0;
    t_acc = cyc_cnt;
    wait_done();
    chk("t1_done_cycle", 32'(cyc_cnt - t_acc + 1), 32'd17);
    chk("t1_rxd",        32'(RXD),       32'hA5);
    chk("t1_mosi_seq",   32'(mosi_seq),  32'hA5);
    chk("t1_sck_pulses", 32'(sck_rises), 32'd8);
    chk("t1_busy_done",  32'(BUSY),      32'h0);
    cyc();

    // 2: DIV=3, MISO tied low
    loop_mode = 1'b0; MISO = 1'b0;
    write_div(8'h03);
    START = 1'b1; WDATA = 8'h3C; cyc(); START = 1'b0;
    t_acc = cyc_cnt;
    wait_done();
    chk("t2_done_cycle", 32'(cyc_cnt - t_acc + 1), 32'd65);
    chk("t2_rxd",        32'(RXD),  32'h00);
    chk("t2_mosi_idle",  32'(MOSI), 32'h1);
    cyc();

    // 3: writes while busy are dropped
    write_div(8'h01);
    d0 = done_seen;
    START = 1'b1; WDATA = 8'h5A; cyc(); START = 1'b0;
    t_acc = cyc_cnt;
    repeat (2) cyc();
    write_ss(8'h02);
    write_div(8'h07);
`ifndef SPI_HOLD_EN
    START = 1'b1; WDATA = 8'hFF; cyc(); START = 1'b0;
`endif
    chk("t3_nss_kept", 32'(nSS), 32'h2);
    wait_done();
    chk("t3_done_cycle", 32'(cyc_cnt - t_acc + 1), 32'd33);
    repeat (40) cyc();
    chk("t3_one_done", 32'(done_seen - d0), 32'd1);

    // 4: reset in the middle of bit 4
    write_div(8'h00);
    write_ss(8'h01);
    loop_mode = 1'b1;
    START = 1'b1; WDATA = 8'h96; cyc(); START = 1'b0;
    repeat (8) cyc();
    d0 = done_seen;
    RST = 1'b1; cyc(); RST = 1'b0;
    chk("t4_sck",  32'(SCK),  32'h0);
    chk("t4_mosi", 32'(MOSI), 32'h1);
    chk("t4_nss",  32'(nSS),  32'h3);
    chk("t4_busy", 32'(BUSY), 32'h0);
    repeat (40) cyc();
    chk("t4_no_done", 32'(done_seen - d0), 32'd0);
    chk("t4_rxd",     32'(RXD), 32'h00);

    // 5: select encodings
    write_ss(8'h03); chk("t5_sel11", 32'(nSS), 32'h3);
    write_ss(8'h00); chk("t5_sel00", 32'(nSS), 32'h3);
    write_ss(8'h01); chk("t5_sel01", 32'(nSS), 32'h2);

`ifdef SPI_HOLD_EN
    // 6: back-to-back bytes through the holding register
    loop_mode = 1'b1;
    START = 1'b1; WDATA = 8'h12; cyc(); START = 1'b0;
    t_acc = cyc_cnt;
    repeat (3) cyc();
    START = 1'b1; WDATA = 8'h34; cyc(); START = 1'b0;
    chk("t6_hold_full", 32'(HOLD_FULL), 32'h1);
    wait_done();
    chk("t6_done1_cycle", 32'(cyc_cnt - t_acc + 1), 32'd17);
    chk("t6_rxd1",        32'(RXD),  32'h12);
    chk("t6_busy_chain",  32'(BUSY), 32'h1);
    t1 = cyc_cnt;
    wait_done();
    chk("t6_spacing", 32'(cyc_cnt - t1), 32'd16);
    chk("t6_rxd2",    32'(RXD), 32'h34);
    cyc();
`endif

    // Randomized transfers with spurious writes and occasional aborts
    for (int t = 0; t < 60; t++) begin
      loop_mode = ($urandom_range(0, 3) == 0);
      rand_miso = !loop_mode;
      if ($urandom_range(0, 1) == 1) write_ss(8'($urandom_range(0, 3)));
      b = 8'($urandom);
      if (b < 8'd4 && $urandom_range(0, 1) == 1) begin
        DIV_WE = 1'b1;
      end else if ($urandom_range(0, 1) == 1) begin
        write_div(8'($urandom_range(0, 3)));
      end
      START = 1'b1; WDATA = b; cyc(); START = 1'b0; DIV_WE = 1'b0;
      abort    = ($urandom_range(0, 9) == 0);
      abort_at = $urandom_range(1, 40);
      budget   = 0;
      while ((m_act || m_donecyc) && budget < 400) begin
        if (abort && budget == abort_at) begin
          RST = 1'b1; cyc(); RST = 1'b0;
        end else begin
          int r;
          r = $urandom_range(0, 15);
          START  = (r == 0) && !m_donecyc && budget < 20;
          SS_WE  = (r == 1);
          DIV_WE = (r == 2);
          WDATA  = (r == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
          cyc();
          START = 1'b0; SS_WE = 1'b0; DIV_WE = 1'b0;
        end
        budget++;
      end
      if (budget >= 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout: transfer %0d still busy after %0d cycles", t, budget);
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
